vend_ctrl: RTL and testbench

- Vending-machine sequencer that owns the coin credit register.
- Accepts coin-insert and product-select buttons, accumulates credit in cents, and checks price against credit.
- Pulses a one-hot vend strobe, then pays out change one coin per clock until credit is zero.
- Sits between the front-panel button synchronisers and the dispenser/coin-return actuators.

---
 rtl/vend_pkg.sv | 15 +
 rtl/vend_ctrl_if.sv | 28 ++
 rtl/vend_change_gen.sv | 20 ++
 rtl/vend_ctrl.sv | 99 +++++++++
 tb/tb_vend_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared coin values, FSM states and output bit positions for vend_ctrl
package vend_pkg;
  localparam logic [7:0] VAL_DOLLAR  = 8'd100;
  localparam logic [7:0] VAL_QUARTER = 8'd25;
  localparam logic [7:0] VAL_DIME    = 8'd10;
  localparam logic [7:0] VAL_NICKEL  = 8'd5;
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  localparam int V_GUM     = 0;
  localparam int V_CANDY   = 1;
  localparam int V_COOKIES = 2;
  localparam int V_CHIPS   = 3;
  localparam int C_NICKEL  = 0;
  localparam int C_DIME    = 1;
  localparam int C_QUARTER = 2;
endpackage

// File: rtl/vend_ctrl_if.sv
// vend_ctrl_if: front-panel buttons in, credit/vend/change/status out
// master drives buttons (panel side), slave is the controller.
// coin_ret exists only when VEND_COIN_RETURN_EN is defined.
interface vend_ctrl_if;
  logic dollar, quarter, dime, nickel;
  logic gum, candy, cookies, chips;
`ifdef VEND_COIN_RETURN_EN
  logic coin_ret;
`endif
  logic [7:0] coins;
  logic [3:0] vend;
  logic [2:0] coin_out;
  logic reject, busy;
  modport master (
`ifdef VEND_COIN_RETURN_EN
    output coin_ret,
`endif
    output dollar, quarter, dime, nickel, gum, candy, cookies, chips,
    input coins, vend, coin_out, reject, busy
  );
  modport slave (
`ifdef VEND_COIN_RETURN_EN
    input coin_ret,
`endif
    input dollar, quarter, dime, nickel, gum, candy, cookies, chips,
    output coins, vend, coin_out, reject, busy
  );
endinterface

// File: rtl/vend_change_gen.sv
// vend_change_gen: greedy change coin selector
// credit in; coin_out one-hot {quarter, dime, nickel} and credit after paying it out.
module vend_change_gen
  import vend_pkg::*;
(
  input  logic [7:0] credit,
  output logic [2:0] coin_out,
  output logic [7:0] next_credit
);
  logic q, d;
  assign q = credit >= VAL_QUARTER;
  assign d = !q && credit >= VAL_DIME;
  always_comb begin
    coin_out = '0;
    coin_out[C_QUARTER] = q;
    coin_out[C_DIME] = d;
    coin_out[C_NICKEL] = !q && !d;
  end
  assign next_credit = credit - (q ? VAL_QUARTER : d ? VAL_DIME : VAL_NICKEL);
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending sequencer owning the credit register, vend strobe and change payout
// Ports: clk, reset_n (async active-low), bus (vend_ctrl_if.slave: buttons in,
// coins/vend/coin_out/reject/busy out). Optional VEND_COIN_RETURN_EN adds coin_ret refunds.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE_GUM     = 50,
  parameter int PRICE_CANDY   = 75,
  parameter int PRICE_COOKIES = 100,
  parameter int PRICE_CHIPS   = 125,
  parameter int MAX_CREDIT    = 250
) (
  input logic clk,
  input logic reset_n,
  vend_ctrl_if.slave bus
);
  if (PRICE_GUM > MAX_CREDIT || PRICE_CANDY > MAX_CREDIT || PRICE_COOKIES > MAX_CREDIT ||
      PRICE_CHIPS > MAX_CREDIT || MAX_CREDIT > 255 || PRICE_GUM % 5 != 0 ||
      PRICE_CANDY % 5 != 0 || PRICE_COOKIES % 5 != 0 || PRICE_CHIPS % 5 != 0 ||
      MAX_CREDIT % 5 != 0) begin : g_bad_params
    $fatal(1, "vend_ctrl: illegal price or credit parameters");
  end
  localparam logic [7:0] PRICES [4] = '{8'(PRICE_GUM), 8'(PRICE_CANDY), 8'(PRICE_COOKIES), 8'(PRICE_CHIPS)};
  state_t state, state_d;
  logic [7:0] coins, coins_d, coin_val, chg_next;
  logic [3:0] coin_in, coin_prev, coin_edge, prod_in, prod_prev, prod_edge;
  logic [2:0] chg_coin;
  logic [1:0] sel, sel_d, prod_idx;
  logic [8:0] sum;
  logic reject, reject_d, ret_edge;
  assign coin_in = {bus.dollar, bus.quarter, bus.dime, bus.nickel};
  assign prod_in = {bus.chips, bus.cookies, bus.candy, bus.gum};
  assign coin_edge = coin_in & ~coin_prev;
  assign prod_edge = prod_in & ~prod_prev;
`ifdef VEND_COIN_RETURN_EN
  logic ret_prev;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ret_prev <= 1'b0;
    else ret_prev <= bus.coin_ret;
  assign ret_edge = bus.coin_ret & ~ret_prev;
`else
  assign ret_edge = 1'b0;
`endif
  // Only the highest-priority edge in each group is acted on; the rest are dropped
  assign coin_val = coin_edge[3] ? VAL_DOLLAR : coin_edge[2] ? VAL_QUARTER :
                    coin_edge[1] ? VAL_DIME : VAL_NICKEL;
  assign prod_idx = prod_edge[V_GUM] ? 2'(V_GUM) : prod_edge[V_CANDY] ? 2'(V_CANDY) :
                    prod_edge[V_COOKIES] ? 2'(V_COOKIES) : 2'(V_CHIPS);
  // Nine-bit sum so an over-limit coin cannot wrap into an apparently legal credit
  assign sum = {1'b0, coins} + {1'b0, coin_val};
  vend_change_gen u_change (.credit(coins), .coin_out(chg_coin), .next_credit(chg_next));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      coins <= '0;
      sel <= '0;
      reject <= 1'b0;
      coin_prev <= '0;
      prod_prev <= '0;
    end else begin
      state <= state_d;
      coins <= coins_d;
      sel <= sel_d;
      reject <= reject_d;
      coin_prev <= coin_in;
      prod_prev <= prod_in;
    end
  always_comb begin
    state_d = state;
    coins_d = coins;
    sel_d = sel;
    reject_d = 1'b0;
    case (state)
      IDLE:
        if (|coin_edge) begin
          coins_d = sum <= 9'(MAX_CREDIT) ? sum[7:0] : coins;
          reject_d = sum > 9'(MAX_CREDIT);
        end else if (|prod_edge) begin
          sel_d = prod_idx;
          state_d = coins >= PRICES[prod_idx] ? VEND : IDLE;
          reject_d = coins < PRICES[prod_idx];
        end else if (ret_edge && coins != '0) state_d = CHANGE;
      VEND: begin
        coins_d = coins - PRICES[sel];
        state_d = coins_d != '0 ? CHANGE : IDLE;
      end
      CHANGE: begin
        coins_d = chg_next;
        state_d = chg_next == '0 ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.coins = coins;
  assign bus.reject = reject;
  assign bus.busy = state != IDLE;
  assign bus.vend = state == VEND ? 4'b0001 << sel : 4'b0000;
  assign bus.coin_out = state == CHANGE ? chg_coin : 3'b000;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: vector table, corner sequences and randomized model check for vend_ctrl
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  vend_ctrl_if bif();
  vend_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bif));
  localparam logic [8:0] D = 9'h100, Q = 9'h080, DI = 9'h040, N = 9'h020;
  localparam logic [8:0] G = 9'h010, CA = 9'h008, CO = 9'h004, CH = 9'h002, R = 9'h001;
`ifdef VEND_COIN_RETURN_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif
  localparam int PRICE [4] = '{50, 75, 100, 125};
  typedef struct packed {
    logic [8:0] in;
    logic [7:0] coins;
    logic [3:0] vend;
    logic [2:0] coin_out;
    logic reject;
    logic busy;
  } vec_t;
  vec_t tbl[$];
  vec_t pend[$];
  int checks = 0, errors = 0;
  int credit;
  bit busy_now;
  logic [8:0] prev;
  function automatic void add(logic [8:0] in, int c, logic [3:0] v, logic [2:0] co, logic r, logic b);
    tbl.push_back({in, 8'(c), v, co, r, b});
  endfunction
  function automatic void hold(int n, int c);
    repeat (n) add(9'h0, c, 4'b0, 3'b0, 1'b0, 1'b0);
  endfunction
  task automatic drive(input logic [8:0] in);
    {bif.dollar, bif.quarter, bif.dime, bif.nickel, bif.gum, bif.candy, bif.cookies, bif.chips} = in[8:1];
`ifdef VEND_COIN_RETURN_EN
    bif.coin_ret = in[0];
`endif
  endtask
  task automatic step(input logic [8:0] in);
    @(negedge clk);
    drive(in);
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input vec_t e);
    checks++;
    if (bif.coins !== e.coins || bif.vend !== e.vend || bif.coin_out !== e.coin_out ||
        bif.reject !== e.reject || bif.busy !== e.busy) begin
      errors++;
      $display("FAIL %s: got coins=%0d vend=%b coin_out=%b reject=%b busy=%b, expected coins=%0d vend=%b coin_out=%b reject=%b busy=%b",
               name, bif.coins, bif.vend, bif.coin_out, bif.reject, bif.busy,
               e.coins, e.vend, e.coin_out, e.reject, e.busy);
    end
  endtask
  function automatic void model_reset();
    credit = 0;
    busy_now = 0;
    prev = '0;
    pend.delete();
  endfunction
  function automatic void push_change(int c);
    int v;
    while (c > 0) begin
      v = c >= 25 ? 25 : c >= 10 ? 10 : 5;
      pend.push_back({9'h0, 8'(c), 4'b0, v == 25 ? 3'b100 : v == 10 ? 3'b010 : 3'b001, 1'b0, 1'b1});
      c -= v;
    end
  endfunction
  // Reference: edges from the previous input word, one queued busy-state per cycle
  function automatic vec_t model_step(logic [8:0] in);
    logic [8:0] ed;
    int cv, p;
    vec_t e;
    ed = in & ~prev;
    prev = in;
    e = '0;
    if (!busy_now) begin
      cv = ed[8] ? 100 : ed[7] ? 25 : ed[6] ? 10 : ed[5] ? 5 : 0;
      if (cv != 0) begin
        if (credit + cv <= 250) credit += cv;
        else e.reject = 1'b1;
      end else if (|ed[4:1]) begin
        p = ed[4] ? 0 : ed[3] ? 1 : ed[2] ? 2 : 3;
        if (credit >= PRICE[p]) begin
          pend.push_back({9'h0, 8'(credit), 4'(1 << p), 3'b0, 1'b0, 1'b1});
          push_change(credit - PRICE[p]);
          credit = 0;
        end else e.reject = 1'b1;
      end else if (RET_EN && ed[0] && credit > 0) begin
        push_change(credit);
        credit = 0;
      end
    end
    if (pend.size() > 0) begin
      e = {e.in, pend[0].coins, pend[0].vend, pend[0].coin_out, e.reject, 1'b1};
      void'(pend.pop_front());
      busy_now = 1;
    end else begin
      e.coins = 8'(credit);
      busy_now = 0;
    end
    return e;
  endfunction
  task automatic do_reset();
    reset_n = 1'b0;
    drive(9'h0);
    model_reset();
    #1;
    check("reset", '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    logic [8:0] rin;
    add(9'h0, 0, 0, 0, 0, 0);
    add(Q, 25, 0, 0, 0, 0); hold(3, 25);
    add(DI, 35, 0, 0, 0, 0); hold(3, 35);
    add(N, 40, 0, 0, 0, 0); hold(1, 40);
    add(CA, 40, 0, 0, 1, 0); hold(1, 40);
    add(D, 140, 0, 0, 0, 0); hold(1, 140);
    add(D | N, 240, 0, 0, 0, 0); hold(1, 240);
    add(D, 240, 0, 0, 1, 0); hold(1, 240);
    add(CH, 240, 4'b1000, 0, 0, 1);
    add(9'h0, 115, 0, 3'b100, 0, 1);
    add(Q, 90, 0, 3'b100, 0, 1);
    add(9'h0, 65, 0, 3'b100, 0, 1);
    add(9'h0, 40, 0, 3'b100, 0, 1);
    add(9'h0, 15, 0, 3'b010, 0, 1);
    add(9'h0, 5, 0, 3'b001, 0, 1);
    hold(1, 0);
    add(D, 100, 0, 0, 0, 0); hold(1, 100);
    add(Q | G, 125, 0, 0, 0, 0); hold(1, 125);
    add(G | CH, 125, 4'b0001, 0, 0, 1);
    add(9'h0, 75, 0, 3'b100, 0, 1);
    add(9'h0, 50, 0, 3'b100, 0, 1);
    add(9'h0, 25, 0, 3'b100, 0, 1);
    hold(1, 0);
    add(D, 100, 0, 0, 0, 0); hold(1, 100);
    add(G, 100, 4'b0001, 0, 0, 1);
    add(9'h0, 50, 0, 3'b100, 0, 1);
    add(9'h0, 25, 0, 3'b100, 0, 1);
    hold(1, 0);
    add(D, 100, 0, 0, 0, 0); hold(1, 100);
    add(D, 200, 0, 0, 0, 0); hold(1, 200);
    add(D, 200, 0, 0, 1, 0); hold(1, 200);
    add(N, 205, 0, 0, 0, 0); hold(1, 205);
    add(Q, 230, 0, 0, 0, 0); hold(1, 230);
    add(DI, 240, 0, 0, 0, 0); hold(1, 240);
    add(DI, 250, 0, 0, 0, 0); hold(1, 250);
    add(N, 250, 0, 0, 1, 0); hold(1, 250);
    add(CO, 250, 4'b0100, 0, 0, 1);
    for (int c = 150; c >= 25; c -= 25) add(9'h0, c, 0, 3'b100, 0, 1);
    hold(1, 0);
    add(Q, 25, 0, 0, 0, 0); hold(1, 25);
    add(Q, 50, 0, 0, 0, 0); hold(1, 50);
    add(Q, 75, 0, 0, 0, 0); hold(1, 75);
    add(CA, 75, 4'b0010, 0, 0, 1);
    hold(1, 0);
    add(G, 0, 0, 0, 1, 0); hold(1, 0);
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), tbl[i]);
    end
    // Reset asserted during the second change coin clears everything at once
    do_reset();
    step(D);
    step(9'h0);
    step(G);
    check("mid_vend", {9'h0, 8'd100, 4'b0001, 3'b0, 1'b0, 1'b1});
    step(9'h0);
    step(9'h0);
    check("mid_change2", {9'h0, 8'd25, 4'b0, 3'b100, 1'b0, 1'b1});
    #2 reset_n = 1'b0;
    #1 check("async_reset", '0);
    @(negedge clk);
    reset_n = 1'b1;
    step(Q);
    check("after_reset_q", {9'h0, 8'd25, 4'b0, 3'b0, 1'b0, 1'b0});
`ifdef VEND_COIN_RETURN_EN
    do_reset();
    step(Q);
    step(9'h0);
    step(DI);
    check("ret_credit", {9'h0, 8'd35, 4'b0, 3'b0, 1'b0, 1'b0});
    step(9'h0);
    step(R);
    check("ret_q", {9'h0, 8'd35, 4'b0, 3'b100, 1'b0, 1'b1});
    step(9'h0);
    check("ret_d", {9'h0, 8'd10, 4'b0, 3'b010, 1'b0, 1'b1});
    step(9'h0);
    check("ret_done", '0);
    step(R);
    check("ret_empty", '0);
`endif
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rin = '0;
      for (int b = 0; b < 9; b++) rin[b] = $urandom_range(0, 3) == 0;
      if (!RET_EN) rin[0] = 1'b0;
      step(rin);
      check($sformatf("rand%0d", i), model_step(rin));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
